// File: rtl/mse_pkg.sv
// Shared types and constants for the MSE result packer: FSM state encoding,
// frame length and the default frame header byte.
package mse_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_e;

  localparam int FRAME_BYTES = 11;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Running frame checksum: XOR of SEQ and every payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/mse_result_packer_if.sv
// Result strobe from the collector and the byte stream toward the host,
// bundled together. The master side is the packer itself.
interface mse_result_packer_if;

  logic [63:0] res_in;
  logic        res_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  res_in,
    input  res_valid,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output res_in,
    output res_valid,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/result_fifo.sv
// Single-clock first-word-fall-through FIFO. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is refused and the
// caller decides what to do about the lost word.
module result_fifo
  import mse_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == (AW+1)'(0));
  assign level = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Decide which operations really happen and the next pointer/count values.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mse_result_packer.sv
// Buffers 64-bit MSE results and serialises each one as an 11-byte frame:
// HEADER, SEQ, D7..D0 (MSB first), CSUM. The frame register shifts left one
// byte per payload handshake so the next byte is always in its top byte.
module mse_result_packer
  import mse_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rstn,
  mse_result_packer_if.master    bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   overflow
);

  state_e      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [63:0] frame_q, frame_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  csum_q, csum_d;
  logic        overflow_q, overflow_d;

  logic        pop_s;
  logic        hs_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [63:0] fifo_dout_s;

  result_fifo #(
    .DATA_W (64),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (bus.res_valid),
    .pop   (pop_s),
    .din   (bus.res_in),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign hs_s         = tx_valid_q && bus.tx_ready;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = (state_q != IDLE);
  assign overflow     = overflow_q;

  // Sticky drop flag: a strobe while full with no simultaneous pop is lost.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.res_valid && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Frame FSM: next state, next output byte and checksum accumulation.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    seq_d      = seq_q;
    csum_d     = csum_q;
    pop_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          frame_d    = fifo_dout_s;
          seq_d      = id_q;
          id_d       = id_q + 8'd1;
          csum_d     = 8'h00;
          tx_data_d  = HEADER;
          tx_valid_d = 1'b1;
          state_d    = HDR;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      HDR: begin
        if (hs_s) begin
          tx_data_d = seq_q;
          csum_d    = csum_step(csum_q, seq_q);
          state_d   = SEQ;
        end else begin
          state_d = HDR;
        end
      end
      SEQ: begin
        if (hs_s) begin
          tx_data_d = frame_q[63:56];
          csum_d    = csum_step(csum_q, frame_q[63:56]);
          frame_d   = {frame_q[55:0], 8'h00};
          cnt_d     = 3'd0;
          state_d   = DATA;
        end else begin
          state_d = SEQ;
        end
      end
      DATA: begin
        if (hs_s) begin
          if (cnt_q == 3'd7) begin
            // csum_q already includes D0, which was folded in when loaded.
            tx_data_d = csum_q;
            state_d   = CSUM;
          end else begin
            tx_data_d = frame_q[63:56];
            csum_d    = csum_step(csum_q, frame_q[63:56]);
            frame_d   = {frame_q[55:0], 8'h00};
            cnt_d     = cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      CSUM: begin
        if (hs_s) begin
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = CSUM;
        end
      end
      default: begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State, output and frame bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      frame_q    <= 64'h0;
      cnt_q      <= 3'd0;
      id_q       <= 8'h00;
      seq_q      <= 8'h00;
      csum_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      seq_q      <= seq_d;
      csum_q     <= csum_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mse_result_packer.sv
// Scoreboard bench for mse_result_packer: stimulus queues the expected frame
// bytes, a negedge monitor pops and compares every accepted byte.
module tb_mse_result_packer;
  import mse_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] fifo_level;
  logic       busy;
  logic       overflow;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_seq = 8'h00;

  always #5 clk = ~clk;

  mse_result_packer_if bus ();

  mse_result_packer #(
    .DEPTH  (DEPTH),
    .HEADER (8'hA5)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .fifo_level (fifo_level),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the 11 bytes the DUT should emit for result r with the next id.
  task automatic expect_frame(input logic [63:0] r);
    logic [7:0] b;
    logic [7:0] acc;
    int         n;
    n = 2;
    exp_q.push_back(8'hA5);
    exp_q.push_back(tb_seq);
    acc = tb_seq;
    for (int i = 0; i < 8; i++) begin
      b = r[63-8*i -: 8];
      acc = acc ^ b;
      exp_q.push_back(b);
      n++;
    end
    exp_q.push_back(acc);
    n++;
    if (n != FRAME_BYTES) $display("frame length model inconsistent");
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic pulse(input logic [63:0] r);
    bus.res_in    = r;
    bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    exp_q.delete();
    tb_seq = 8'h00;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy && fifo_level == 3'd0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  // Monitor: every accepted byte is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rstn && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %h expected none", bus.tx_data);
      end else begin
        check("tx_byte", {56'd0, bus.tx_data}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         found;
    logic [63:0] r;
    logic [7:0]  nb;

    bus.res_in    = 64'h0;
    bus.res_valid = 1'b0;
    bus.tx_ready  = 1'b0;
    tick();
    tick();
    check("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
    check("rst_tx_data",  {56'd0, bus.tx_data},  64'd0);
    check("rst_busy",     {63'd0, busy},         64'd0);
    check("rst_overflow", {63'd0, overflow},     64'd0);
    check("rst_level",    {61'd0, fifo_level},   64'd0);
    rstn = 1'b1;

    // Single frame, latency and final idle.
    bus.tx_ready = 1'b1;
    expect_frame(64'h0123_4567_89AB_CDEF);
    pulse(64'h0123_4567_89AB_CDEF);
    check("lat_level1",  {61'd0, fifo_level},   64'd1);
    check("lat_novalid", {63'd0, bus.tx_valid}, 64'd0);
    tick();
    check("lat_valid",   {63'd0, bus.tx_valid}, 64'd1);
    check("lat_header",  {56'd0, bus.tx_data},  64'hA5);
    wait_idle("frame1_done");
    check("frame1_busy", {63'd0, busy}, 64'd0);

    // Stall while D5 (8'h45) is presented.
    expect_frame(64'h0123_4567_89AB_CDEF);
    pulse(64'h0123_4567_89AB_CDEF);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tx_valid && bus.tx_data == 8'h45) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("stall_reach", {63'd0, found}, 64'd1);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data",  {56'd0, bus.tx_data},  64'h45);
      check("stall_valid", {63'd0, bus.tx_valid}, 64'd1);
    end
    bus.tx_ready = 1'b1;
    wait_idle("stall_done");

    // Overflow: six back-to-back results with the host stalled.
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = 64'hA0B1_C2D3_E4F5_0600 + 64'(i);
      if (i < 5) expect_frame(r);
      pulse(r);
    end
    check("ovf_level",    {61'd0, fifo_level},  64'd4);
    check("ovf_flag",     {63'd0, overflow},    64'd1);
    check("ovf_busy",     {63'd0, busy},        64'd1);
    check("ovf_header",   {56'd0, bus.tx_data}, 64'hA5);
    bus.tx_ready = 1'b1;
    wait_idle("ovf_drain");
    check("ovf_sticky",   {63'd0, overflow},    64'd1);

    // 257 spaced results: SEQ wraps 0xFF -> 0x00.
    do_reset();
    bus.tx_ready = 1'b1;
    for (int n = 0; n < 257; n++) begin
      nb = n[7:0];
      r  = 64'h0F1E_2D3C_4B5A_6978 ^ {8{nb}} ^ 64'(n);
      expect_frame(r);
      pulse(r);
      for (int k = 0; k < 19; k++) tick();
    end
    wait_idle("wrap_done");

    // Reset in DATA with two results buffered.
    bus.tx_ready = 1'b0;
    expect_frame(64'h1111_2222_3333_4444);
    pulse(64'h1111_2222_3333_4444);
    pulse(64'h5555_6666_7777_8888);
    pulse(64'h9999_AAAA_BBBB_CCCC);
    check("mid_level", {61'd0, fifo_level}, 64'd2);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    bus.tx_ready = 1'b0;
    check("mid_d7",    {56'd0, bus.tx_data}, 64'h11);
    rstn = 1'b0;
    tick();
    check("mid_rst_valid", {63'd0, bus.tx_valid}, 64'd0);
    check("mid_rst_busy",  {63'd0, busy},         64'd0);
    check("mid_rst_level", {61'd0, fifo_level},   64'd0);
    check("mid_rst_ovf",   {63'd0, overflow},     64'd0);
    rstn = 1'b1;
    exp_q.delete();
    tb_seq = 8'h00;
    bus.tx_ready = 1'b1;
    expect_frame(64'hDEAD_BEEF_0BAD_F00D);
    pulse(64'hDEAD_BEEF_0BAD_F00D);
    wait_idle("post_rst_done");

    // Push coincides with an IDLE pop while full: nothing is dropped.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = 64'h7700_0000_0000_0000 | (64'(i) << 8) | 64'(i * 3);
      expect_frame(r);
      pulse(r);
    end
    check("full_level", {61'd0, fifo_level}, 64'd4);
    check("full_ovf",   {63'd0, overflow},   64'd0);
    bus.tx_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("full_idle_reach", {63'd0, found}, 64'd1);
    expect_frame(64'h5A5A_0F0F_F0F0_A5A5);
    pulse(64'h5A5A_0F0F_F0F0_A5A5);
    check("same_cycle_level", {61'd0, fifo_level}, 64'd4);
    check("same_cycle_ovf",   {63'd0, overflow},   64'd0);
    wait_idle("same_cycle_done");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
